// File: rtl/denormalizer.sv
// ---------------------------------------------------------------------------
// denormalizer
//
// Turns normalized fixed-point samples y back into raw data units:
//     x = mu + y * sigma
// mu and sigma are captured once when a frame starts and stay fixed until
// the frame ends. One sample per cycle, three pipeline stages, CNT samples
// per frame, and a single-cycle pulse when the frame's last result leaves.
//
// Parameters
//   CNT   samples per frame (>= 1)
//   FRAC  fractional bits of data_in and sigma_in (1..30)
//
// Ports
//   clk               clock, everything on posedge
//   rst_n             asynchronous active-low reset
//   start_en          frame start request, only honoured in IDLE
//   mu_in             signed mean in raw units, captured on start
//   sigma_in          unsigned std-dev Q(32-FRAC).FRAC, captured on start
//   data_in           signed normalized sample Q(32-FRAC).FRAC
//   data_in_valid     sample strobe, no backpressure
//   data_out          signed reconstructed sample, saturated to 32 bits
//   data_out_valid    output strobe
//   busy              high while a frame is in RUN or FLUSH
//   overflow_flag     sticky, set by any saturation in the current frame
//   process_end_flag  one-cycle pulse when the frame is complete
// ---------------------------------------------------------------------------
module denormalizer #(
    parameter int CNT  = 1000,
    parameter int FRAC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_en,
    input  logic [31:0] mu_in,
    input  logic [31:0] sigma_in,
    input  logic [31:0] data_in,
    input  logic        data_in_valid,
    output logic [31:0] data_out,
    output logic        data_out_valid,
    output logic        busy,
    output logic        overflow_flag,
    output logic        process_end_flag
);

    localparam int CW = $clog2(CNT + 1);
    localparam int SH = 2 * FRAC;
    localparam logic [CW-1:0] LAST_IDX = CW'(CNT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CNT);

    localparam logic signed [65:0] SAT_MAX = {35'b0, {31{1'b1}}};
    localparam logic signed [65:0] SAT_MIN = {{35{1'b1}}, 31'b0};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t                r_state;
    logic        [31:0]    r_mu;
    logic        [31:0]    r_sigma;
    logic        [CW-1:0]  r_in_cnt;
    logic        [CW-1:0]  r_out_cnt;

    logic                  r_v1;
    logic signed [64:0]    r_prod;
    logic                  r_v2;
    logic signed [65:0]    r_sum;

    logic                  w_accept;
    logic signed [64:0]    w_a;
    logic signed [64:0]    w_b;
    logic signed [64:0]    w_prod;
    logic signed [64:0]    w_shift;
    logic signed [65:0]    w_sum;
    logic                  w_sat_hi;
    logic                  w_sat_lo;
    logic        [31:0]    w_sat_val;
    logic                  w_out_done;

    assign w_accept = (r_state == RUN) && data_in_valid;

    // sigma is unsigned, so it is zero-extended before the signed multiply;
    // 65 bits hold the full 32x33 signed product exactly.
    assign w_a    = {{33{data_in[31]}}, data_in};
    assign w_b    = {33'b0, r_sigma};
    assign w_prod = w_a * w_b;

    // Arithmetic shift floors toward -inf; no rounding term is added.
    assign w_shift = r_prod >>> SH;
    assign w_sum   = {w_shift[64], w_shift} + {{34{r_mu[31]}}, r_mu};

    assign w_sat_hi  = (r_sum > SAT_MAX);
    assign w_sat_lo  = (r_sum < SAT_MIN);
    assign w_sat_val = w_sat_hi ? 32'h7FFF_FFFF :
                       w_sat_lo ? 32'h8000_0000 : r_sum[31:0];

    // The final output of the frame is the one that brings out_cnt to CNT;
    // looking one count early lets the end pulse follow it by one cycle.
    assign w_out_done = (r_state == FLUSH) && data_out_valid &&
                        (r_out_cnt == LAST_IDX);

    // Datapath pipeline: product, shift+add, saturate. Valids travel with
    // their data so bubbles and ordering are preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1           <= 1'b0;
            r_prod         <= '0;
            r_v2           <= 1'b0;
            r_sum          <= '0;
            data_out_valid <= 1'b0;
            data_out       <= '0;
        end else begin
            r_v1           <= w_accept;
            r_prod         <= w_prod;
            r_v2           <= r_v1;
            r_sum          <= w_sum;
            data_out_valid <= r_v2;
            if (r_v2) begin
                data_out <= w_sat_val;
            end
        end
    end

    // Frame control FSM with its registered status outputs. The overflow
    // set sits before the case so a start in IDLE clears it last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_mu             <= '0;
            r_sigma          <= '0;
            r_in_cnt         <= '0;
            r_out_cnt        <= '0;
            busy             <= 1'b0;
            overflow_flag    <= 1'b0;
            process_end_flag <= 1'b0;
        end else begin
            process_end_flag <= 1'b0;

            if (data_out_valid && (r_out_cnt != CNT_MAX)) begin
                r_out_cnt <= r_out_cnt + CW'(1);
            end

            if (r_v2 && (w_sat_hi || w_sat_lo)) begin
                overflow_flag <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (start_en) begin
                        r_mu          <= mu_in;
                        r_sigma       <= sigma_in;
                        r_in_cnt      <= '0;
                        r_out_cnt     <= '0;
                        overflow_flag <= 1'b0;
                        busy          <= 1'b1;
                        r_state       <= RUN;
                    end
                end
                RUN: begin
                    if (data_in_valid) begin
                        if (r_in_cnt != CNT_MAX) begin
                            r_in_cnt <= r_in_cnt + CW'(1);
                        end
                        if (r_in_cnt == LAST_IDX) begin
                            r_state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (w_out_done) begin
                        busy             <= 1'b0;
                        process_end_flag <= 1'b1;
                        r_state          <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_denormalizer.sv
// ---------------------------------------------------------------------------
// tb_denormalizer
//
// Directed bench for the denormalizer with CNT=4, FRAC=16. Each driven sample
// queues its hand-computed result and the cycle it should appear on; a
// monitor records what the design actually produces, and the two lists are
// compared after every frame.
// ---------------------------------------------------------------------------
module tb_denormalizer;

    localparam int CNT  = 4;
    localparam int FRAC = 16;

    logic        clk;
    logic        rst_n;
    logic        start_en;
    logic [31:0] mu_in;
    logic [31:0] sigma_in;
    logic [31:0] data_in;
    logic        data_in_valid;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic        busy;
    logic        overflow_flag;
    logic        process_end_flag;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        ovf;
        logic        busy;
    } outRec_t;

    typedef struct {
        int   cyc;
        logic busy;
    } pefRec_t;

    outRec_t obsQ[$];
    outRec_t expQ[$];
    pefRec_t pefQ[$];
    int      expPefQ[$];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    denormalizer #(
        .CNT  (CNT),
        .FRAC (FRAC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_en         (start_en),
        .mu_in            (mu_in),
        .sigma_in         (sigma_in),
        .data_in          (data_in),
        .data_in_valid    (data_in_valid),
        .data_out         (data_out),
        .data_out_valid   (data_out_valid),
        .busy             (busy),
        .overflow_flag    (overflow_flag),
        .process_end_flag (process_end_flag)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a stuck design still ends the run with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: counts edges and, 1 time unit after each, records every
    // output strobe and end pulse together with the edge number it followed.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (data_out_valid) begin
            obsQ.push_back('{cyc, data_out, overflow_flag, busy});
        end
        if (process_end_flag) begin
            pefQ.push_back('{cyc, busy});
        end
    end

    // Single comparison point: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Request a frame start with the given statistics for one cycle.
    task automatic startFrame(input logic [31:0] mu, input logic [31:0] sigma);
        start_en = 1'b1;
        mu_in    = mu;
        sigma_in = sigma;
        step();
        start_en = 1'b0;
    endtask

    // Drive one input cycle. When want is set, the result is expected
    // three edges after the cycle in which it was driven.
    task automatic applyStimulus(input logic [31:0] y, input logic v, input logic want,
                                 input logic [31:0] expVal, input logic expOvf);
        data_in       = y;
        data_in_valid = v;
        if (want) expQ.push_back('{cyc + 3, expVal, expOvf, 1'b1});
        step();
        data_in_valid = 1'b0;
        data_in       = '0;
    endtask

    // The end pulse belongs one cycle after the last queued output.
    task automatic expectPef();
        expPefQ.push_back(expQ[$].cyc + 1);
    endtask

    // Compare everything the monitor captured against what was queued.
    task automatic finishFrame(input string name);
        int n;
        checkOutput({name, ".outCount"}, obsQ.size(), expQ.size());
        n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s.outCycle[%0d]", name, i), obsQ[i].cyc, expQ[i].cyc);
            checkOutput($sformatf("%s.outData[%0d]", name, i), obsQ[i].data, expQ[i].data);
            checkOutput($sformatf("%s.outOvf[%0d]", name, i), obsQ[i].ovf, expQ[i].ovf);
            checkOutput($sformatf("%s.outBusy[%0d]", name, i), obsQ[i].busy, expQ[i].busy);
        end
        checkOutput({name, ".pefCount"}, pefQ.size(), expPefQ.size());
        n = (pefQ.size() < expPefQ.size()) ? pefQ.size() : expPefQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s.pefCycle[%0d]", name, i), pefQ[i].cyc, expPefQ[i]);
            checkOutput($sformatf("%s.pefBusy[%0d]", name, i), pefQ[i].busy, 1'b0);
        end
        obsQ.delete();
        expQ.delete();
        pefQ.delete();
        expPefQ.delete();
    endtask

    // Basic arithmetic frame, reused after the mid-frame reset.
    task automatic basicFrame(input string name);
        startFrame(32'd1000, 32'h0002_0000);
        checkOutput({name, ".busyRise"}, busy, 1'b1);
        applyStimulus(32'h0001_8000, 1'b1, 1'b1, 32'd1003, 1'b0);
        applyStimulus(32'hFFFE_8000, 1'b1, 1'b1, 32'd997,  1'b0);
        applyStimulus(32'hFFFF_C000, 1'b1, 1'b1, 32'd999,  1'b0);
        applyStimulus(32'h0000_0000, 1'b1, 1'b1, 32'd1000, 1'b0);
        expectPef();
        waitCycles(8);
        checkOutput({name, ".busyIdle"}, busy, 1'b0);
        finishFrame(name);
    endtask

    // Main directed sequence.
    initial begin
        rst_n         = 1'b0;
        start_en      = 1'b0;
        mu_in         = '0;
        sigma_in      = '0;
        data_in       = '0;
        data_in_valid = 1'b0;

        waitCycles(3);
        checkOutput("rst.dataOut", data_out, 32'h0);
        checkOutput("rst.valid", data_out_valid, 1'b0);
        checkOutput("rst.busy", busy, 1'b0);
        checkOutput("rst.ovf", overflow_flag, 1'b0);
        checkOutput("rst.pef", process_end_flag, 1'b0);
        rst_n = 1'b1;
        waitCycles(2);

        basicFrame("basic");

        // Positive saturation, then the flag stays set for unsaturated outputs.
        startFrame(32'h7FFF_FFF0, 32'h0020_0000);
        checkOutput("sat.ovfStart", overflow_flag, 1'b0);
        applyStimulus(32'h0001_0000, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1);
        applyStimulus(32'h0000_0000, 1'b1, 1'b1, 32'h7FFF_FFF0, 1'b1);
        applyStimulus(32'h0000_0000, 1'b1, 1'b1, 32'h7FFF_FFF0, 1'b1);
        applyStimulus(32'h0000_0000, 1'b1, 1'b1, 32'h7FFF_FFF0, 1'b1);
        expectPef();
        waitCycles(8);
        checkOutput("sat.ovfHeld", overflow_flag, 1'b1);
        finishFrame("sat");

        // Negative saturation; the start must clear the sticky flag first.
        startFrame(32'h8000_0010, 32'h0001_0000);
        checkOutput("neg.ovfCleared", overflow_flag, 1'b0);
        applyStimulus(32'hFFE0_0000, 1'b1, 1'b1, 32'h8000_0000, 1'b1);
        applyStimulus(32'h0001_0000, 1'b1, 1'b1, 32'h8000_0011, 1'b1);
        applyStimulus(32'h0000_0000, 1'b1, 1'b1, 32'h8000_0010, 1'b1);
        applyStimulus(32'hFFFF_0000, 1'b1, 1'b1, 32'h8000_000F, 1'b1);
        expectPef();
        waitCycles(8);
        finishFrame("neg");

        // Ignored inputs: IDLE strobes, a sample alongside the start, gapped
        // samples, and a fifth strobe once the frame is already flushing.
        applyStimulus(32'h0001_0000, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(32'h0002_0000, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(32'h0003_0000, 1'b1, 1'b0, 32'h0, 1'b0);
        start_en      = 1'b1;
        mu_in         = -32'sd500;
        sigma_in      = 32'h0000_8000;
        data_in       = 32'h0064_0000;
        data_in_valid = 1'b1;
        step();
        start_en      = 1'b0;
        data_in_valid = 1'b0;
        applyStimulus(32'h0004_0000, 1'b1, 1'b1, -32'sd498, 1'b0);
        waitCycles(2);
        applyStimulus(32'hFFF8_0000, 1'b1, 1'b1, -32'sd504, 1'b0);
        waitCycles(2);
        applyStimulus(32'h0000_0001, 1'b1, 1'b1, -32'sd500, 1'b0);
        waitCycles(2);
        applyStimulus(32'hFFFF_FFFF, 1'b1, 1'b1, -32'sd501, 1'b0);
        expectPef();
        applyStimulus(32'h0010_0000, 1'b1, 1'b0, 32'h0, 1'b0);
        waitCycles(8);
        finishFrame("ignore");

        // Start during RUN is ignored; start in the end-pulse cycle is taken.
        startFrame(32'd10, 32'h0001_0000);
        applyStimulus(32'h0001_0000, 1'b1, 1'b1, 32'd11, 1'b0);
        start_en = 1'b1;
        mu_in    = 32'd5000;
        applyStimulus(32'h0002_0000, 1'b1, 1'b1, 32'd12, 1'b0);
        start_en = 1'b0;
        applyStimulus(32'h0003_0000, 1'b1, 1'b1, 32'd13, 1'b0);
        applyStimulus(32'h0004_0000, 1'b1, 1'b1, 32'd14, 1'b0);
        expectPef();
        for (int k = 0; k < 20 && !process_end_flag; k++) step();
        checkOutput("b2b.pefSeen", process_end_flag, 1'b1);
        startFrame(-32'sd20, 32'h0002_0000);
        checkOutput("b2b.busy2", busy, 1'b1);
        applyStimulus(32'h0001_0000, 1'b1, 1'b1, -32'sd18, 1'b0);
        applyStimulus(32'hFFFF_0000, 1'b1, 1'b1, -32'sd22, 1'b0);
        applyStimulus(32'h0000_8000, 1'b1, 1'b1, -32'sd19, 1'b0);
        applyStimulus(32'h000A_0000, 1'b1, 1'b1, 32'd0,     1'b0);
        expectPef();
        waitCycles(8);
        finishFrame("b2b");

        // Reset with two samples still in the pipeline.
        startFrame(32'd1000, 32'h0002_0000);
        applyStimulus(32'h0001_8000, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(32'hFFFE_8000, 1'b1, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midRst.dataOut", data_out, 32'h0);
        checkOutput("midRst.valid", data_out_valid, 1'b0);
        checkOutput("midRst.busy", busy, 1'b0);
        checkOutput("midRst.pef", process_end_flag, 1'b0);
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(10);
        finishFrame("midRst");

        basicFrame("afterRst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
